// File: rtl/bus_driver_bank_if.sv
// Bus bundle between the logic-module models and the bus driver bank.
// The master side drives mode/control and inputs; the slave side is the driver bank.
interface bus_driver_bank_if #(
  parameter int CHANNELS = 6
);
  logic [1:0]          mode;
  logic                oe;
  logic                strobe;
  logic [CHANNELS-1:0] in_a;
  logic [CHANNELS-1:0] in_b;
  logic [CHANNELS-1:0] in_c;
  logic [CHANNELS-1:0] out_d;
  logic [CHANNELS-1:0] out_e;
  logic                busy;

  modport master (
    output mode, oe, strobe, in_a, in_b, in_c,
    input  out_d, out_e, busy
  );

  modport slave (
    input  mode, oe, strobe, in_a, in_b, in_c,
    output out_d, out_e, busy
  );
endinterface

// File: rtl/bus_driver_bank.sv
// Clocked bank of OR-type bus driver pairs (D = A|C, E = B|C) with pass,
// strobe-latch and minimum-width pulse-stretch modes, gated by output enable.
module bus_driver_bank #(
  parameter int CHANNELS = 6,
  parameter int STRETCH  = 8,
  parameter int CW       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_driver_bank_if.slave bus
);

  localparam logic [CW-1:0] LOAD_C = CW'(STRETCH - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

  if ((CHANNELS < 1) || (CHANNELS > 32)) begin : g_bad_channels
    $error("bus_driver_bank: CHANNELS must be in 1..32");
  end
  if ((STRETCH < 1) || (STRETCH > 255)) begin : g_bad_stretch
    $error("bus_driver_bank: STRETCH must be in 1..255");
  end
  if (STRETCH > ((2 ** CW) - 1)) begin : g_bad_cw
    $error("bus_driver_bank: STRETCH does not fit in a CW-bit counter");
  end

  logic [CHANNELS-1:0]         nd_s;
  logic [CHANNELS-1:0]         ne_s;
  logic [CHANNELS-1:0]         reg_d_r;
  logic [CHANNELS-1:0]         reg_e_r;
  logic [CHANNELS-1:0]         reg_d_nxt_s;
  logic [CHANNELS-1:0]         reg_e_nxt_s;
  logic [CHANNELS-1:0][CW-1:0] cnt_d_r;
  logic [CHANNELS-1:0][CW-1:0] cnt_e_r;
  logic [CHANNELS-1:0][CW-1:0] cnt_d_nxt_s;
  logic [CHANNELS-1:0][CW-1:0] cnt_e_nxt_s;
  logic                        busy_r;
  logic                        busy_nxt_s;

  // One stretch step for a single output: returns {output, next counter}.
  function automatic logic [CW:0] stretch_step(input logic trig, input logic [CW-1:0] cnt);
    logic [CW:0] res;
    if (trig) begin
      res = {1'b1, LOAD_C};
    end else if (cnt != ZERO_C) begin
      res = {1'b1, cnt - ONE_C};
    end else begin
      res = {1'b0, ZERO_C};
    end
    return res;
  endfunction

  // Next-state of output registers, stretch counters and busy for the current mode.
  always_comb begin
    nd_s        = bus.in_a | bus.in_c;
    ne_s        = bus.in_b | bus.in_c;
    reg_d_nxt_s = reg_d_r;
    reg_e_nxt_s = reg_e_r;
    cnt_d_nxt_s = {(CHANNELS * CW){1'b0}};
    cnt_e_nxt_s = {(CHANNELS * CW){1'b0}};
    busy_nxt_s  = 1'b0;
    case (bus.mode)
      2'd1: begin
        if (bus.strobe) begin
          reg_d_nxt_s = nd_s;
          reg_e_nxt_s = ne_s;
        end else begin
          reg_d_nxt_s = reg_d_r;
          reg_e_nxt_s = reg_e_r;
        end
      end
      2'd2: begin
        for (int i = 0; i < CHANNELS; i++) begin
          {reg_d_nxt_s[i], cnt_d_nxt_s[i]} = stretch_step(nd_s[i], cnt_d_r[i]);
          {reg_e_nxt_s[i], cnt_e_nxt_s[i]} = stretch_step(ne_s[i], cnt_e_r[i]);
        end
        // Including the counters being drained this edge keeps busy aligned
        // with the full stretched pulse, last cycle included.
        busy_nxt_s = (|cnt_d_nxt_s) | (|cnt_e_nxt_s) | (|cnt_d_r) | (|cnt_e_r);
      end
      default: begin
        reg_d_nxt_s = nd_s;
        reg_e_nxt_s = ne_s;
      end
    endcase
  end

  // Bank state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_d_r <= {CHANNELS{1'b0}};
      reg_e_r <= {CHANNELS{1'b0}};
      cnt_d_r <= {(CHANNELS * CW){1'b0}};
      cnt_e_r <= {(CHANNELS * CW){1'b0}};
      busy_r  <= 1'b0;
    end else begin
      reg_d_r <= reg_d_nxt_s;
      reg_e_r <= reg_e_nxt_s;
      cnt_d_r <= cnt_d_nxt_s;
      cnt_e_r <= cnt_e_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign bus.out_d = reg_d_r & {CHANNELS{bus.oe}};
  assign bus.out_e = reg_e_r & {CHANNELS{bus.oe}};
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_bus_driver_bank.sv
// Directed bench for bus_driver_bank: a time-window model of the three modes
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_bus_driver_bank;

  localparam int C = 6;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bus_driver_bank_if #(.CHANNELS(C)) bus ();

  bus_driver_bank #(.CHANNELS(C), .STRETCH(S), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: in stretch mode an output is high iff its input was sampled high
  // within the last S edges since stretch mode was entered.
  int         t = 0;
  int         last_d [C];
  int         last_e [C];
  logic [C-1:0] m_d = '0;
  logic [C-1:0] m_e = '0;
  logic         m_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    automatic logic [C-1:0] nd = bus.in_a | bus.in_c;
    automatic logic [C-1:0] ne = bus.in_b | bus.in_c;
    automatic logic [C-1:0] xd = m_d;
    automatic logic [C-1:0] xe = m_e;
    automatic int tn = t + 1;
    automatic int ld;
    automatic int le;
    if (!rst_n) begin
      m_d    <= '0;
      m_e    <= '0;
      m_busy <= 1'b0;
      for (int i = 0; i < C; i++) begin
        last_d[i] <= -1000;
        last_e[i] <= -1000;
      end
    end else begin
      t <= tn;
      if (bus.mode == 2'd2) begin
        for (int i = 0; i < C; i++) begin
          ld = nd[i] ? tn : last_d[i];
          le = ne[i] ? tn : last_e[i];
          xd[i] = (tn - ld) < S;
          xe[i] = (tn - le) < S;
          last_d[i] <= ld;
          last_e[i] <= le;
        end
        m_busy <= (S > 1) && ((xd | xe) != '0);
      end else begin
        if (bus.mode == 2'd1) begin
          if (bus.strobe) begin
            xd = nd;
            xe = ne;
          end
        end else begin
          xd = nd;
          xe = ne;
        end
        for (int i = 0; i < C; i++) begin
          last_d[i] <= -1000;
          last_e[i] <= -1000;
        end
        m_busy <= 1'b0;
      end
      m_d <= xd;
      m_e <= xe;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if ((bus.out_d !== (m_d & {C{bus.oe}})) || (bus.out_e !== (m_e & {C{bus.oe}})) ||
        (bus.busy !== m_busy)) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: out_d=%b want %b, out_e=%b want %b, busy=%b want %b",
               $time, bus.out_d, m_d & {C{bus.oe}}, bus.out_e, m_e & {C{bus.oe}},
               bus.busy, m_busy);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          hits;
  int          bhits;
  logic [11:0] pat_d;
  logic [11:0] pat_e;

  initial begin
    bus.mode   = 2'd0;
    bus.oe     = 1'b0;
    bus.strobe = 1'b0;
    bus.in_a   = '0;
    bus.in_b   = '0;
    bus.in_c   = '0;

    // Held in reset while inputs toggle
    for (int k = 0; k < 4; k++) begin
      bus.oe   = 1'b1;
      bus.in_a = (k % 2 == 0) ? 6'h3F : 6'h15;
      bus.in_b = (k % 2 == 0) ? 6'h2A : 6'h3F;
      bus.in_c = 6'(k);
      bus.mode = 2'(k);
      step();
    end
    chk("reset_out_d", 32'(bus.out_d), 32'h0);
    chk("reset_out_e", 32'(bus.out_e), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);

    // Release, pass mode
    rst_n = 1'b1;
    bus.mode = 2'd0;
    bus.oe   = 1'b1;
    bus.in_a = 6'b000001;
    bus.in_b = '0;
    bus.in_c = '0;
    step();
    chk("pass_first_d", 32'(bus.out_d), 32'h01);
    chk("pass_first_e", 32'(bus.out_e), 32'h00);

    bus.in_a = '0;
    bus.in_c = 6'b100000;
    step();
    chk("pass_c_d", 32'(bus.out_d), 32'h20);
    chk("pass_c_e", 32'(bus.out_e), 32'h20);

    // Latch mode
    bus.in_c = '0;
    step();
    bus.mode   = 2'd1;
    bus.in_b   = 6'b010101;
    bus.strobe = 1'b0;
    step();
    chk("latch_no_strobe", 32'(bus.out_e), 32'h00);
    bus.strobe = 1'b1;
    step();
    bus.strobe = 1'b0;
    chk("latch_capture", 32'(bus.out_e), 32'h15);
    bus.in_b = '0;
    step();
    step();
    chk("latch_hold", 32'(bus.out_e), 32'h15);
    chk("latch_hold_d", 32'(bus.out_d), 32'h00);

    // Stretch: single pulse
    bus.mode = 2'd2;
    step();
    bus.in_a = 6'b000100;
    step();
    bus.in_a = '0;
    hits = 0;
    bhits = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_d[2]) hits++;
      if (bus.busy) bhits++;
      step();
    end
    chk("stretch_width", 32'(hits), 32'd8);
    chk("stretch_busy_width", 32'(bhits), 32'd8);

    // Stretch: re-trigger extends the pulse with no gap
    bus.in_a = 6'b000100;
    step();
    bus.in_a = '0;
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_d[2]) hits++;
      bus.in_a = (k == 3) ? 6'b000100 : 6'b000000;
      step();
    end
    bus.in_a = '0;
    chk("retrigger_width", 32'(hits), 32'd12);

    // Stretch with oe gating mid-pulse
    bus.in_c = 6'b000001;
    step();
    bus.in_c = '0;
    for (int k = 0; k < 12; k++) begin
      bus.oe = ((k >= 3) && (k <= 5)) ? 1'b0 : 1'b1;
      #1;
      pat_d[k] = bus.out_d[0];
      pat_e[k] = bus.out_e[0];
      step();
    end
    bus.oe = 1'b1;
    chk("oe_pattern_d", 32'(pat_d), 32'h0C7);
    chk("oe_pattern_e", 32'(pat_e), 32'h0C7);

    // Asynchronous reset mid-stretch
    bus.in_a = 6'b000100;
    step();
    bus.in_a = '0;
    step();
    step();
    chk("pre_reset_high", 32'(bus.out_d), 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_d", 32'(bus.out_d), 32'h00);
    chk("async_reset_busy", 32'(bus.busy), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_no_pulse", 32'(bus.out_d), 32'h00);

    // Leave stretch mid-pulse
    bus.in_a = 6'b000100;
    step();
    bus.in_a = '0;
    bus.in_b = 6'b001000;
    step();
    bus.in_b = '0;
    chk("mid_pulse_busy", 32'(bus.busy), 32'h1);
    chk("mid_pulse_d", 32'(bus.out_d), 32'h04);
    chk("mid_pulse_e", 32'(bus.out_e), 32'h08);
    bus.mode = 2'd0;
    bus.in_a = 6'b010000;
    step();
    chk("leave_stretch_busy", 32'(bus.busy), 32'h0);
    chk("leave_stretch_d", 32'(bus.out_d), 32'h10);
    chk("leave_stretch_e", 32'(bus.out_e), 32'h00);

    // Reserved mode behaves as pass
    bus.mode = 2'd3;
    bus.in_a = 6'b000010;
    step();
    chk("mode3_pass", 32'(bus.out_d), 32'h02);

    // Entering stretch starts from idle counters
    bus.mode = 2'd2;
    bus.in_a = '0;
    step();
    chk("enter_stretch_idle", 32'(bus.out_d), 32'h00);
    chk("enter_stretch_busy", 32'(bus.busy), 32'h0);

    // Entering latch holds the current output
    bus.mode = 2'd0;
    bus.in_a = 6'b000001;
    step();
    bus.mode   = 2'd1;
    bus.strobe = 1'b0;
    bus.in_a   = '0;
    step();
    step();
    chk("enter_latch_hold", 32'(bus.out_d), 32'h01);

    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_driver_bank.md
Name: bus_driver_bank

Overview:
- Parametrised, clocked successor to the fixed six-pair OR-type bus driver module in the PDP-8/I FPGA model.
- Provides CHANNELS driver pairs. Each pair computes out_d = in_a | in_c and out_e = in_b | in_c, as before.
- Adds three bank-wide operating modes: registered pass-through, strobe-latched hold, and minimum-width pulse stretching. Stretching emulates DEC pulse widths at the FPGA clock rate.
- Sits between the logic-module models and the backplane bus nets that feed long-line receivers.

Parameters:
- CHANNELS, 6, number of driver pairs (1..32).
- STRETCH, 8, minimum asserted width of an output in clk cycles in stretch mode (1..255).
- CW, 8, width of the stretch counter; the implementation must satisfy STRETCH <= 2**CW-1 (elaboration-time check).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  bank mode: 0 = pass, 1 = latch, 2 = stretch, 3 = reserved (behaves as pass).
- oe  input  1  output enable. Outputs are forced to 0 while low; internal state keeps running.
- strobe  input  1  latch-mode capture strobe.
- in_a  input  CHANNELS  per-channel A input.
- in_b  input  CHANNELS  per-channel B input.
- in_c  input  CHANNELS  per-channel common input; ORs into both outputs of its pair.
- out_d  output  CHANNELS  per-channel D output = A|C after mode processing.
- out_e  output  CHANNELS  per-channel E output = B|C after mode processing.
- busy  output  1  high while any stretch counter is non-zero.

Behaviour:
- Reset:
  - rst_n low asynchronously clears out_d, out_e, busy, all latches and all stretch counters to 0.
  - Release is synchronous to the first clk edge with rst_n high.
- Combinational terms: nd[i] = in_a[i] | in_c[i]; ne[i] = in_b[i] | in_c[i]. All inputs are sampled on rising clk.
- Pass mode (0 or 3): the internal register takes nd/ne every cycle. Latency is exactly 1 cycle from input to output.
- Latch mode (1):
  - When strobe is high at a rising edge, the register captures nd/ne. Otherwise it holds.
  - Output changes 1 cycle after the strobe edge.
  - Strobe held high for several cycles behaves as transparent-registered.
- Stretch mode (2):
  - The D and E outputs of each channel have independent counters.
  - Input high at an edge: counter loads STRETCH-1 and the output register is set to 1 on that edge.
  - Input low and counter > 0: counter decrements and the output stays 1.
  - Input low and counter = 0: output is 0.
  - Result: a 1-cycle input pulse gives an output high for exactly STRETCH cycles, starting 1 cycle after the input edge.
  - A re-trigger (input high again while counting) reloads the counter, extending the pulse. There is no gap.
  - An input held high N cycles gives an output high for N+STRETCH-1 cycles.
  - STRETCH = 1 is equivalent to pass mode.
- Mode change:
  - Takes effect on the next edge.
  - Leaving stretch clears all counters on that edge. The output then follows the new mode's rule from the same edge.
  - Entering stretch starts with counters at 0.
  - Entering latch holds the current output value until the next strobe.
- oe: out_d = reg_d & oe; out_e = reg_e & oe. This is a combinational gate after the register.
  - Registers, latches and counters are unaffected, so raising oe mid-stretch exposes the remaining pulse.
- busy: registered OR of all counters being non-zero. It is 0 outside stretch mode.
- Reset mid-stretch or mid-latch: all state is lost. Outputs drop to 0 immediately, without waiting for clk.
- Channels are fully independent. in_c[i] affects only pair i.

Test Plan:
- Reset, then hold rst_n low while toggling inputs -> out_d, out_e and busy stay 0. After release with mode=0, oe=1, in_a=6'b000001 -> out_d=6'b000001 one cycle later, out_e=0.
- Mode 0, in_c=6'b100000 with a and b = 0 -> next cycle out_d[5]=1 and out_e[5]=1. All other outputs are 0.
- Mode 1: in_b=6'b010101 with strobe low -> outputs unchanged. Pulse strobe for 1 cycle -> out_e=6'b010101 the next cycle. Change in_b to 0 -> out_e stays 6'b010101.
- Mode 2, STRETCH=8: 1-cycle pulse on in_a[2] -> out_d[2] high for exactly 8 cycles and busy high for the same window. Re-pulse at output cycle 5 -> out_d[2] stays high for 12 cycles total.
- Mode 2: trigger in_c[0], drop oe at output cycle 3, raise oe at cycle 6 -> out_d[0] and out_e[0] read 0 in cycles 3-5 and 1 in cycles 6-7, then 0.
- Mode 2 mid-pulse: assert rst_n low -> outputs 0 asynchronously. Separately, switch mode to 0 mid-pulse -> busy=0 and outputs follow the inputs on the next edge.
